ex_stage: RTL

- Execute stage of the 5-stage MIPS pipeline. Sits directly downstream of the decode stage and consumes its ID/EX register outputs.
- Contains the ALU control decode, the ALU, the branch-target adder and the destination-register mux.
- Registers all results in an internal EX/MEM pipeline register that feeds the memory stage.
- The EX/MEM register supports hold (stall) and bubble insertion (flush).

---
 rtl/ex_stage.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: ALU control, ALU, branch adder, dest mux, EX/MEM register
module ex_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [8:0]            id_ex_control,
    input  logic [DATA_W-1:0]     id_ex_npc,
    input  logic [DATA_W-1:0]     id_ex_read_data1,
    input  logic [DATA_W-1:0]     id_ex_read_data2,
    input  logic [DATA_W-1:0]     id_ex_sign_ext,
    input  logic [REG_ADDR_W-1:0] id_ex_instr_2016,
    input  logic [REG_ADDR_W-1:0] id_ex_instr_1511,
    output logic [1:0]            ex_mem_wb_ctrl,
    output logic [2:0]            ex_mem_m_ctrl,
    output logic [DATA_W-1:0]     ex_mem_branch_target,
    output logic                  ex_mem_zero,
    output logic [DATA_W-1:0]     ex_mem_alu_result,
    output logic [DATA_W-1:0]     ex_mem_write_data,
    output logic [REG_ADDR_W-1:0] ex_mem_dest_reg
);

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_NOR,
        ALU_NONE
    } alu_sel_e;

    logic                  reg_dst;
    logic [1:0]            alu_op;
    logic                  alu_src;
    logic [DATA_W-1:0]     op_a;
    logic [DATA_W-1:0]     op_b;
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     branch_target;
    alu_sel_e              alu_sel;
    logic [DATA_W-1:0]     alu_result;
    logic                  slt_bit;

    logic [1:0]            wb_ctrl_d,       wb_ctrl_q;
    logic [2:0]            m_ctrl_d,        m_ctrl_q;
    logic [DATA_W-1:0]     branch_target_d, branch_target_q;
    logic                  zero_d,          zero_q;
    logic [DATA_W-1:0]     alu_result_d,    alu_result_q;
    logic [DATA_W-1:0]     write_data_d,    write_data_q;
    logic [REG_ADDR_W-1:0] dest_reg_d,      dest_reg_q;

    assign reg_dst = id_ex_control[8];
    assign alu_op  = id_ex_control[7:6];
    assign alu_src = id_ex_control[5];

    assign op_a          = id_ex_read_data1;
    assign op_b          = alu_src ? id_ex_sign_ext : id_ex_read_data2;
    assign dest          = reg_dst ? id_ex_instr_1511 : id_ex_instr_2016;
    assign branch_target = id_ex_npc + {id_ex_sign_ext[DATA_W-3:0], 2'b00};
    assign slt_bit       = $signed(op_a) < $signed(op_b);

    always_comb begin
        alu_sel = ALU_NONE;
        case (alu_op)
            2'b00: alu_sel = ALU_ADD;
            2'b01: alu_sel = ALU_SUB;
            2'b11: alu_sel = ALU_OR;
            default: begin
                case (id_ex_sign_ext[5:0])
                    6'b100000: alu_sel = ALU_ADD;
                    6'b100010: alu_sel = ALU_SUB;
                    6'b100100: alu_sel = ALU_AND;
                    6'b100101: alu_sel = ALU_OR;
                    6'b101010: alu_sel = ALU_SLT;
                    6'b100111: alu_sel = ALU_NOR;
                    default:   alu_sel = ALU_NONE;
                endcase
            end
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (alu_sel)
            ALU_ADD: alu_result = op_a + op_b;
            ALU_SUB: alu_result = op_a - op_b;
            ALU_AND: alu_result = op_a & op_b;
            ALU_OR:  alu_result = op_a | op_b;
            ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, slt_bit};
            ALU_NOR: alu_result = ~(op_a | op_b);
            default: alu_result = '0;
        endcase
    end

    // Priority: reset, then flush (bubble), then stall (hold), then load.
    always_comb begin
        wb_ctrl_d       = wb_ctrl_q;
        m_ctrl_d        = m_ctrl_q;
        branch_target_d = branch_target_q;
        zero_d          = zero_q;
        alu_result_d    = alu_result_q;
        write_data_d    = write_data_q;
        dest_reg_d      = dest_reg_q;
        if (flush) begin
            wb_ctrl_d       = '0;
            m_ctrl_d        = '0;
            branch_target_d = '0;
            zero_d          = 1'b0;
            alu_result_d    = '0;
            write_data_d    = '0;
            dest_reg_d      = '0;
        end else if (!stall) begin
            wb_ctrl_d       = id_ex_control[1:0];
            m_ctrl_d        = id_ex_control[4:2];
            branch_target_d = branch_target;
            zero_d          = (alu_result == '0);
            alu_result_d    = alu_result;
            write_data_d    = id_ex_read_data2;
            dest_reg_d      = dest;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_ctrl_q       <= '0;
            m_ctrl_q        <= '0;
            branch_target_q <= '0;
            zero_q          <= 1'b0;
            alu_result_q    <= '0;
            write_data_q    <= '0;
            dest_reg_q      <= '0;
        end else begin
            wb_ctrl_q       <= wb_ctrl_d;
            m_ctrl_q        <= m_ctrl_d;
            branch_target_q <= branch_target_d;
            zero_q          <= zero_d;
            alu_result_q    <= alu_result_d;
            write_data_q    <= write_data_d;
            dest_reg_q      <= dest_reg_d;
        end
    end

    assign ex_mem_wb_ctrl       = wb_ctrl_q;
    assign ex_mem_m_ctrl        = m_ctrl_q;
    assign ex_mem_branch_target = branch_target_q;
    assign ex_mem_zero          = zero_q;
    assign ex_mem_alu_result    = alu_result_q;
    assign ex_mem_write_data    = write_data_q;
    assign ex_mem_dest_reg      = dest_reg_q;

endmodule
